// File: rtl/cpu_defines.sv
// rtl/cpu_defines.sv - shared CPU constants, fetch response record and kseg translation
package cpu_defines;

    localparam logic [31:0] RESET_PC  = 32'hbfc00000;
    localparam logic [31:0] KSEG_MASK = 32'h1fffffff;
    localparam int          SRAM_DW   = 32;

    typedef struct packed {
        logic [31:0]        pc;
        logic [SRAM_DW-1:0] inst;
        logic               adel;
    } fetch_rsp_t;

    localparam int RSP_W = $bits(fetch_rsp_t);

    // kseg0/kseg1 are unmapped windows onto the low 512 MB; everything else passes through.
    function automatic logic [31:0] kseg_translate(input logic [31:0] vaddr);
        return (vaddr[31:30] == 2'b10) ? (vaddr & KSEG_MASK) : vaddr;
    endfunction

endpackage

// File: rtl/fetch_rsp_fifo.sv
// rtl/fetch_rsp_fifo.sv - synchronous response FIFO with flush clear and occupancy count
module fetch_rsp_fifo #(
    parameter int  WIDTH = 65,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push_i & (count_q != (AW+1)'(DEPTH)) & ~clear_i;
    assign do_pop  = pop_i & (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: empty_o qualifies every read of it.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_data_o = mem_q[rd_ptr_q];
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;

endmodule

// File: rtl/inst_fetch_responder.sv
// rtl/inst_fetch_responder.sv - in-order fetch responder between PC and IF/ID with SRAM read and flush
module inst_fetch_responder
    import cpu_defines::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_pc,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_pc,
    output logic [31:0] rsp_inst,
    output logic        rsp_adel,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic        inf_valid_q, inf_valid_d;
    logic [31:0] inf_pc_q,    inf_pc_d;
    logic        inf_adel_q,  inf_adel_d;

    logic [CW-1:0] fifo_count;
    logic [CW-1:0] cnt;
    logic          fifo_empty;
    logic          acc, req_aligned, pop;
    fetch_rsp_t    push_entry, head_entry;

    // The in-flight slot holds a credit too, so the buffer can never overflow on push.
    assign cnt         = fifo_count + CW'(inf_valid_q);
    assign req_ready   = resetn & ~flush & (cnt < CW'(DEPTH));
    assign acc         = req_valid & req_ready;
    assign req_aligned = (req_pc[1:0] == 2'b00);

    assign inst_sram_en   = acc & req_aligned;
    assign inst_sram_wen  = 4'b0000;
    assign inst_sram_addr = kseg_translate(req_pc);

    always_comb begin
        inf_valid_d = acc;
        inf_pc_d    = inf_pc_q;
        inf_adel_d  = inf_adel_q;
        if (acc) begin
            inf_pc_d   = req_pc;
            inf_adel_d = ~req_aligned;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inf_valid_q <= 1'b0;
            inf_pc_q    <= '0;
            inf_adel_q  <= 1'b0;
        end else begin
            inf_valid_q <= inf_valid_d;
            inf_pc_q    <= inf_pc_d;
            inf_adel_q  <= inf_adel_d;
        end
    end

    always_comb begin
        push_entry      = '0;
        push_entry.pc   = inf_pc_q;
        push_entry.inst = inf_adel_q ? '0 : inst_sram_rdata;
        push_entry.adel = inf_adel_q;
    end

    assign pop = rsp_valid & rsp_ready;

    // Flush clears the buffer and, through the FIFO's clear priority, drops the in-flight push.
    fetch_rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .clear_i     (flush),
        .push_i      (inf_valid_q),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_data_o (head_entry),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign rsp_valid = ~fifo_empty;
    assign rsp_pc    = rsp_valid ? head_entry.pc   : '0;
    assign rsp_inst  = rsp_valid ? head_entry.inst : '0;
    assign rsp_adel  = rsp_valid & head_entry.adel;

endmodule

// File: tb/tb_inst_fetch_responder.sv
// tb/tb_inst_fetch_responder.sv - directed self-checking bench for inst_fetch_responder
module tb_inst_fetch_responder;

    localparam logic [31:0] MAGIC = 32'h5a5a5a5a;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_pc = '0;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_pc;
    logic [31:0] rsp_inst;
    logic        rsp_adel;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata = '0;

    inst_fetch_responder #(.DEPTH(4)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_pc          (req_pc),
        .flush           (flush),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_pc          (rsp_pc),
        .rsp_inst        (rsp_inst),
        .rsp_adel        (rsp_adel),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= inst_sram_addr ^ MAGIC;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_rsp = 0;
    int first_cyc = -1;
    int last_cyc = -1;

    logic [31:0] exp_pc[$];
    logic [31:0] exp_inst[$];
    logic        exp_adel[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid === 1'b1 && rsp_ready) begin
            if (exp_pc.size() == 0) begin
                check("spurious_rsp_queue", 32'(exp_pc.size()), 32'd1);
            end else begin
                logic [31:0] epc, einst;
                logic        eadel;
                epc   = exp_pc.pop_front();
                einst = exp_inst.pop_front();
                eadel = exp_adel.pop_front();
                check("rsp_pc", rsp_pc, epc);
                check("rsp_inst", rsp_inst, einst);
                check("rsp_adel", 32'(rsp_adel), 32'(eadel));
            end
            n_rsp++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
        end
    end

    task automatic issue(input logic [31:0] pc, input logic [31:0] addr, input logic exp_rdy);
        logic mis;
        mis = (pc[1:0] != 2'b00);
        req_valid = 1'b1;
        req_pc    = pc;
        @(negedge clk);
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("sram_addr", inst_sram_addr, addr);
        check("sram_en", 32'(inst_sram_en), 32'(exp_rdy & ~mis));
        if (exp_rdy) begin
            exp_pc.push_back(pc);
            exp_inst.push_back(mis ? 32'h0 : (addr ^ MAGIC));
            exp_adel.push_back(mis);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (exp_pc.size() == 0) break;
            @(posedge clk); #1;
        end
        check("drain_left", 32'(exp_pc.size()), 32'd0);
    endtask

    task automatic clear_exp();
        exp_pc.delete();
        exp_inst.delete();
        exp_adel.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state with a request presented
        req_valid = 1'b1;
        req_pc    = 32'hbfc00000;
        #3;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_sram_en", 32'(inst_sram_en), 32'd0);
        check("rst_rsp_pc", rsp_pc, 32'h0);
        check("rst_rsp_inst", rsp_inst, 32'h0);
        check("rst_rsp_adel", 32'(rsp_adel), 32'd0);
        check("rst_sram_wen", 32'(inst_sram_wen), 32'd0);
        @(posedge clk); #1;
        resetn    = 1'b1;
        req_valid = 1'b0;

        // Reset mid-stream loses pending requests
        rsp_ready = 1'b0;
        issue(32'hbfc00000, 32'h1fc00000, 1'b1);
        issue(32'hbfc00004, 32'h1fc00004, 1'b1);
        req_valid = 1'b1;
        req_pc    = 32'hbfc00008;
        resetn    = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_sram_en", 32'(inst_sram_en), 32'd0);
        clear_exp();
        @(posedge clk); #1;
        resetn    = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
            @(posedge clk); #1;
        end

        // First request after reset: two-cycle latency
        issue(32'hbfc00000, 32'h1fc00000, 1'b1);
        req_valid = 1'b0;
        @(negedge clk);
        check("lat_t1_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_t2_rsp_valid", 32'(rsp_valid), 32'd1);
        check("lat_rsp_pc", rsp_pc, 32'hbfc00000);
        check("lat_rsp_inst", rsp_inst, 32'h459a5a5a);
        @(posedge clk); #1;

        // Streaming: 8 back-to-back, one response per cycle
        n_rsp = 0;
        first_cyc = -1;
        for (int i = 0; i < 8; i++)
            issue(32'hbfc00000 + 32'(i * 4), 32'h1fc00000 + 32'(i * 4), 1'b1);
        req_valid = 1'b0;
        drain(20);
        check("stream_count", 32'(n_rsp), 32'd8);
        check("stream_span", 32'(last_cyc - first_cyc), 32'd7);

        // Backpressure: exactly 4 accepted, pop does not free a credit the same cycle
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            issue(32'hbfc00100 + 32'(i * 4), 32'h1fc00100 + 32'(i * 4), 1'b1);
        req_valid = 1'b1;
        req_pc    = 32'hbfc00110;
        repeat (3) begin
            @(negedge clk);
            check("bp_full_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_pop_cycle_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        issue(32'hbfc00110, 32'h1fc00110, 1'b1);
        issue(32'hbfc00114, 32'h1fc00114, 1'b1);
        req_valid = 1'b0;
        drain(20);

        // Flush: 3 buffered + 1 in flight
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            issue(32'hbfc00200 + 32'(i * 4), 32'h1fc00200 + 32'(i * 4), 1'b1);
        req_valid = 1'b1;
        req_pc    = 32'hbfc00300;
        flush     = 1'b1;
        @(negedge clk);
        check("flush_req_ready", 32'(req_ready), 32'd0);
        check("flush_sram_en", 32'(inst_sram_en), 32'd0);
        @(posedge clk); #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        clear_exp();
        rsp_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("postflush_rsp_valid", 32'(rsp_valid), 32'd0);
            @(posedge clk); #1;
        end
        issue(32'h80001000, 32'h00001000, 1'b1);
        req_valid = 1'b0;
        drain(20);

        // Misaligned between aligned requests
        issue(32'hbfc00010, 32'h1fc00010, 1'b1);
        issue(32'hbfc00002, 32'h1fc00002, 1'b1);
        issue(32'hbfc00014, 32'h1fc00014, 1'b1);
        req_valid = 1'b0;
        drain(20);

        // kuseg passes through untranslated
        issue(32'h00400000, 32'h00400000, 1'b1);
        req_valid = 1'b0;
        drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
